// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_updown_counter
// Brief    : Multi-digit BCD up/down counter with programmable modulus,
//            parallel load with legality fixing and cascade carry.
//            Define BCD_SAT_EN to saturate at the limits instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_updown_counter #(
    parameter int DIGITS  = 2,
    parameter int MOD_MAX = 99
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry_out,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int c_W = 4 * DIGITS;

    function automatic logic [c_W-1:0] f_to_bcd(input int value);
        logic [c_W-1:0] res;
        int             v;
        res = '0;
        v   = value;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = 4'(v % 10);
            v             = v / 10;
        end
        return res;
    endfunction

    localparam logic [c_W-1:0] c_MAX_BCD = f_to_bcd(MOD_MAX);
    localparam logic [c_W-1:0] c_ZERO    = '0;

    logic [c_W-1:0]    r_count;
    logic              r_wrap;
    logic              r_load_err;

    logic [c_W-1:0]    w_inc;
    logic [c_W-1:0]    w_dec;
    logic [c_W-1:0]    w_fix;
    logic [DIGITS-1:0] w_cy;
    logic [DIGITS-1:0] w_bw;
    logic [DIGITS-1:0] w_nib_bad;
    logic              w_at_max;
    logic              w_at_zero;
    logic              w_limit;
    logic              w_load_over;
    logic              w_load_bad;
    logic [c_W-1:0]    w_load_val;

    // Ripple carry/borrow: digit i steps only when every lower digit rolls over.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] w_d;
        logic [3:0] w_lv;
        assign w_d  = r_count[4*i +: 4];
        assign w_lv = load_val[4*i +: 4];

        if (i == 0) begin : g_first
            assign w_cy[i] = 1'b1;
            assign w_bw[i] = 1'b1;
        end else begin : g_rest
            assign w_cy[i] = w_cy[i-1] & (r_count[4*(i-1) +: 4] == 4'd9);
            assign w_bw[i] = w_bw[i-1] & (r_count[4*(i-1) +: 4] == 4'd0);
        end

        assign w_inc[4*i +: 4] = w_cy[i] ? ((w_d == 4'd9) ? 4'd0 : w_d + 4'd1) : w_d;
        assign w_dec[4*i +: 4] = w_bw[i] ? ((w_d == 4'd0) ? 4'd9 : w_d - 4'd1) : w_d;
        assign w_nib_bad[i]    = (w_lv > 4'd9);
        assign w_fix[4*i +: 4] = w_nib_bad[i] ? 4'd9 : w_lv;
    end

    assign w_at_max  = (r_count == c_MAX_BCD);
    assign w_at_zero = (r_count == c_ZERO);
    assign w_limit   = up ? w_at_max : w_at_zero;

    // With every nibble in 0..9, unsigned compare of BCD vectors orders decimally.
    assign w_load_over = (w_fix > c_MAX_BCD);
    assign w_load_val  = w_load_over ? c_MAX_BCD : w_fix;
    assign w_load_bad  = (|w_nib_bad) | w_load_over;

`ifdef BCD_SAT_EN
    assign carry_out = 1'b0;
`else
    assign carry_out = en & ~load & w_limit;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (load) begin
            r_count    <= w_load_val;
            r_load_err <= w_load_bad;
            r_wrap     <= 1'b0;
        end else begin
            r_load_err <= 1'b0;
            if (en) begin
                if (w_limit) begin
`ifdef BCD_SAT_EN
                    r_wrap  <= 1'b1;
`else
                    r_count <= up ? c_ZERO : c_MAX_BCD;
                    r_wrap  <= 1'b1;
`endif
                end else begin
                    r_count <= up ? w_inc : w_dec;
                    r_wrap  <= 1'b0;
                end
            end else begin
                r_wrap <= 1'b0;
            end
        end
    end

    assign count    = r_count;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bcd_updown_counter
// Brief    : Scoreboard bench for bcd_updown_counter (2-digit mod-60 and a
//            1-digit cascade). Expectations follow BCD_SAT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_updown_counter;

    localparam int c_MAX = 59;

    typedef struct {
        logic [7:0] cnt;
        logic       wr;
        logic       er;
    } exp_t;

    logic       clk;
    logic       rst, en, up, load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       carry_out, wrap, load_err;

    logic       c_rst, c_en, c_up, c_load;
    logic [3:0] c_lv;
    logic [3:0] lo_count, hi_count;
    logic       lo_carry, hi_carry, lo_wrap, hi_wrap, lo_err, hi_err;

    int         total = 0;
    int         bad   = 0;
    exp_t       q[$];
    logic [7:0] cq[$];
    int         m  = 0;
    int         ck = 0;
    bit         casc_done = 0;

    bcd_updown_counter #(.DIGITS(2), .MOD_MAX(c_MAX)) u_dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count), .carry_out(carry_out), .wrap(wrap), .load_err(load_err)
    );

    bcd_updown_counter #(.DIGITS(1), .MOD_MAX(9)) u_lo (
        .clk(clk), .rst(c_rst), .en(c_en), .up(c_up), .load(c_load), .load_val(c_lv),
        .count(lo_count), .carry_out(lo_carry), .wrap(lo_wrap), .load_err(lo_err)
    );

    bcd_updown_counter #(.DIGITS(1), .MOD_MAX(5)) u_hi (
        .clk(clk), .rst(c_rst), .en(lo_carry), .up(c_up), .load(c_load), .load_val(c_lv),
        .count(hi_count), .carry_out(hi_carry), .wrap(hi_wrap), .load_err(hi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one edge worth of inputs and queues the post-edge expectation.
    task automatic step(input logic r, input logic e, input logic u,
                        input logic l, input logic [7:0] lv);
        exp_t x;
        int   hi, lo, val;
        logic fixed, exp_c;
        @(negedge clk);
        rst = r; en = e; up = u; load = l; load_val = lv;
        #1;
`ifdef BCD_SAT_EN
        exp_c = 1'b0;
`else
        exp_c = e & ~l & (u ? (m == c_MAX) : (m == 0));
`endif
        chk("carry_out", {31'd0, carry_out}, {31'd0, exp_c});
        x.wr = 1'b0;
        x.er = 1'b0;
        if (!r) begin
            m = 0;
        end else if (l) begin
            hi    = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
            lo    = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
            fixed = (lv[7:4] > 4'd9) || (lv[3:0] > 4'd9);
            val   = hi * 10 + lo;
            x.er  = fixed || (val > c_MAX);
            m     = (val > c_MAX) ? c_MAX : val;
        end else if (e) begin
            if (u && m == c_MAX) begin
`ifndef BCD_SAT_EN
                m = 0;
`endif
                x.wr = 1'b1;
            end else if (!u && m == 0) begin
`ifndef BCD_SAT_EN
                m = c_MAX;
`endif
                x.wr = 1'b1;
            end else begin
                m = u ? m + 1 : m - 1;
            end
        end
        x.cnt = bcd2(m);
        q.push_back(x);
    endtask

    task automatic cstep(input logic r, input logic e);
        logic exp_lc, exp_hc;
        @(negedge clk);
        c_rst = r; c_en = e;
        #1;
`ifdef BCD_SAT_EN
        exp_lc = 1'b0;
        exp_hc = 1'b0;
`else
        exp_lc = e & (ck % 10 == 9);
        exp_hc = e & (ck == 59);
`endif
        chk("casc_lo_carry", {31'd0, lo_carry}, {31'd0, exp_lc});
        chk("casc_hi_carry", {31'd0, hi_carry}, {31'd0, exp_hc});
        if (!r) ck = 0;
`ifdef BCD_SAT_EN
        else if (e && ck < 9) ck = ck + 1;
`else
        else if (e) ck = (ck + 1) % 60;
`endif
        cq.push_back(bcd2(ck));
    endtask

    // Monitors: registered outputs are checked one step after each queued edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("count", {24'd0, count}, {24'd0, x.cnt});
                chk("wrap", {31'd0, wrap}, {31'd0, x.wr});
                chk("load_err", {31'd0, load_err}, {31'd0, x.er});
            end
        end
    end

    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (cq.size() > 0) begin
                e = cq.pop_front();
                chk("casc_count", {24'd0, hi_count, lo_count}, {24'd0, e});
            end
        end
    end

    initial begin
        c_rst = 1'b0; c_en = 1'b0; c_up = 1'b1; c_load = 1'b0; c_lv = 4'd0;
        repeat (2) cstep(1'b0, 1'b0);
        repeat (62) cstep(1'b1, 1'b1);
        cstep(1'b1, 1'b0);
        casc_done = 1'b1;
    end

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
        repeat (2) step(0, 0, 1, 0, 8'h00);
        repeat (60) step(1, 1, 1, 0, 8'h00);
        step(1, 0, 0, 1, 8'h10);
        repeat (12) step(1, 1, 0, 0, 8'h00);
        step(1, 0, 0, 1, 8'h7A);
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 1, 8'h35);
        step(1, 0, 1, 1, 8'h59);
        step(1, 1, 1, 1, 8'h20);
        step(0, 1, 1, 0, 8'h00);
        step(1, 1, 0, 0, 8'h00);
        step(1, 0, 0, 1, 8'hA3);
        step(1, 0, 0, 1, 8'h5F);
        step(1, 0, 0, 1, 8'h60);
        step(1, 0, 0, 1, 8'h09);
        for (int i = 0; i < 6; i++) step(1, i[0], 1, 0, 8'h00);
        step(1, 1, 0, 0, 8'h00);
        step(1, 1, 1, 0, 8'h00);
        step(1, 1, 0, 0, 8'h00);
        step(1, 0, 1, 1, 8'h58);
        repeat (3) step(1, 1, 1, 0, 8'h00);
        step(1, 0, 0, 1, 8'h01);
        repeat (2) step(1, 1, 0, 0, 8'h00);
        step(1, 0, 0, 1, 8'h59);
        step(1, 1, 1, 0, 8'h00);
        step(0, 1, 1, 0, 8'h00);
        step(1, 0, 1, 0, 8'h00);

        @(negedge clk);
        en = 1'b0; load = 1'b0;
        for (int k = 0; k < 200 && (!casc_done || q.size() != 0 || cq.size() != 0); k++)
            @(posedge clk);
        repeat (2) @(posedge clk);
        #2;
        if (!casc_done || q.size() != 0 || cq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d/%0d expected 0", q.size(), cq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
